ms_div: RTL and testbench

- Sequential signed restoring divider. It is the inverse-operation companion to the ms_mult sequential multiplier and sits in the same switch/LED demo datapath.
- Accepts dividend and divisor on the packed switch bus when i_start is pulsed. Produces quotient and remainder after a fixed iteration count, one quotient bit per cycle.
- Handshake is identical to ms_mult: a single-cycle i_start, and a level o_ready meaning "idle and results valid".

---
 rtl/ms_div.sv | 145 ++++++++++++++
 tb/tb_ms_div.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ms_div.sv
// rtl/ms_div.sv - sequential signed restoring divider
// One quotient bit per cycle; fixed DW+3 cycle latency with divide-by-zero and overflow flags.
module ms_div #(
  parameter int DW = 9
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2*DW-1:0] i_sw,
  output logic [DW-1:0]   o_quot,
  output logic [DW-1:0]   o_rem,
  output logic            o_dz,
  output logic            o_ovf,
  output logic            o_ready
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_FIX} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] qm_q, qm_d, bm_q, bm_d;
  logic [DW:0]   pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [DW-1:0] quot_q, quot_d, rem_q, rem_d;
  logic          odz_q, odz_d, oovf_q, oovf_d;
  logic [DW+1:0] trial;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      qm_q    <= '0;
      bm_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      odz_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qm_q    <= qm_d;
      bm_q    <= bm_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      odz_q   <= odz_d;
      oovf_q  <= oovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    qm_d    = qm_q;
    bm_d    = bm_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    odz_d   = odz_q;
    oovf_d  = oovf_q;
    // Quotient bits enter qm_q from the right as dividend bits leave on the left.
    trial   = {pr_q, qm_q[DW-1]} - {2'b00, bm_q};

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_sw[2*DW-1:DW];
          b_d     = i_sw[DW-1:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sq_d    = a_q[DW-1] ^ b_q[DW-1];
        sr_d    = a_q[DW-1];
        qm_d    = a_q[DW-1] ? (DW'(0) - a_q) : a_q;
        bm_d    = b_q[DW-1] ? (DW'(0) - b_q) : b_q;
        dz_d    = (b_q == '0);
        ovf_d   = (a_q == MIN_NEG) && (b_q == '1);
        pr_d    = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (!trial[DW+1]) begin
          pr_d = trial[DW:0];
          qm_d = {qm_q[DW-2:0], 1'b1};
        end else begin
          pr_d = {pr_q[DW-1:0], qm_q[DW-1]};
          qm_d = {qm_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        odz_d  = 1'b0;
        oovf_d = 1'b0;
        if (dz_q) begin
          quot_d = a_q[DW-1] ? MIN_NEG : MAX_POS;
          rem_d  = a_q;
          odz_d  = 1'b1;
        end else if (ovf_q) begin
          quot_d = MAX_POS;
          rem_d  = '0;
          oovf_d = 1'b1;
        end else begin
          quot_d = sq_q ? (DW'(0) - qm_q) : qm_q;
          rem_d  = sr_q ? (DW'(0) - pr_q[DW-1:0]) : pr_q[DW-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_quot  = quot_q;
  assign o_rem   = rem_q;
  assign o_dz    = odz_q;
  assign o_ovf   = oovf_q;
  assign o_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_ms_div.sv
// tb/tb_ms_div.sv - scoreboard bench for ms_div
// Driver pushes expected results; a negedge monitor pops on each rising o_ready.
module tb_ms_div;
  localparam int DW = 9;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ovf;
    int            lat;
    int            issue;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*DW-1:0] sw;
  logic [DW-1:0]   o_quot, o_rem;
  logic            o_dz, o_ovf, o_ready;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   prev_ready = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  logic [2*DW+1:0] held;

  ms_div #(.DW(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sw    (sw),
    .o_quot  (o_quot),
    .o_rem   (o_rem),
    .o_dz    (o_dz),
    .o_ovf   (o_ovf),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_ready && !prev_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got q=%0d r=%0d, required no result", $signed(o_quot), $signed(o_rem));
        end else begin
          mon_e = sb.pop_front();
          if (o_quot !== mon_e.q || o_rem !== mon_e.r || o_dz !== mon_e.dz || o_ovf !== mon_e.ovf
              || (cyc - mon_e.issue + 1) != mon_e.lat) begin
            fails++;
            $display("FAIL result: got q=%0d r=%0d dz=%b ovf=%b lat=%0d, required q=%0d r=%0d dz=%b ovf=%b lat=%0d",
                     $signed(o_quot), $signed(o_rem), o_dz, o_ovf, cyc - mon_e.issue + 1,
                     $signed(mon_e.q), $signed(mon_e.r), mon_e.dz, mon_e.ovf, mon_e.lat);
          end
        end
      end else if (!o_ready) begin
        tests++;
        if ({o_quot, o_rem, o_dz, o_ovf} !== held) begin
          fails++;
          $display("FAIL busy_hold: got %h, required %h", {o_quot, o_rem, o_dz, o_ovf}, held);
        end
      end
      if (o_ready) held = {o_quot, o_rem, o_dz, o_ovf};
      prev_ready = o_ready;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got o_ready=0, required 1");
    end
  endtask

  task automatic start_op(input int a, input int b, input int q, input int r,
                          input bit dz, input bit ovf, input int lat);
    exp_t e;
    wait_ready();
    e.q     = 9'(q);
    e.r     = 9'(r);
    e.dz    = dz;
    e.ovf   = ovf;
    e.lat   = lat;
    e.issue = cyc + 1;
    sb.push_back(e);
    sw    = {9'(a), 9'(b)};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic rand_op();
    int a, b, q, r, mode;
    bit dz, ovf;
    mode = int'($urandom_range(0, 9));
    a = int'($urandom_range(0, 511)) - 256;
    b = int'($urandom_range(0, 511)) - 256;
    if (mode == 0) b = 0;
    if (mode == 1) begin a = -256; b = -1; end
    if (mode == 2) b = int'($urandom_range(0, 16)) - 8;
    dz = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q = (a >= 0) ? 255 : -256;
      r = a;
    end else if (a == -256 && b == -1) begin
      ovf = 1'b1;
      q = 255;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
    start_op(a, b, q, r, dz, ovf, 12);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    sw = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({o_quot, o_rem, o_dz, o_ovf, o_ready} !== {18'd0, 3'b001}) begin
      fails++;
      $display("FAIL reset_state: got %h, required %h", {o_quot, o_rem, o_dz, o_ovf, o_ready}, {18'd0, 3'b001});
    end
    held = '0;
    mon_en = 1'b1;

    start_op(100, 7, 14, 2, 0, 0, 12);
    start_op(-100, 7, -14, -2, 0, 0, 12);
    start_op(100, -7, -14, 2, 0, 0, 12);
    start_op(-100, -7, 14, -2, 0, 0, 12);
    start_op(21, 14, 1, 7, 0, 0, 12);
    start_op(5, 9, 0, 5, 0, 0, 12);
    start_op(21, 0, 255, 21, 1, 0, 12);
    start_op(-21, 0, -256, -21, 1, 0, 12);
    start_op(-256, -1, 255, 0, 0, 1, 12);
    start_op(-256, 1, -256, 0, 0, 0, 12);
    start_op(255, -256, 0, 255, 0, 0, 12);

    start_op(20, 12, 1, 8, 0, 0, 12);
    repeat (4) @(negedge clk);
    sw = {9'd32, 9'd100};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready();
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (!o_ready) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL ready_stays_high: got %0d low cycles, required 0", n);
    end

    start_op(100, 7, 0, 0, 0, 0, 6);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start_op(32, 100, 0, 32, 0, 0, 12);

    repeat (1000) rand_op();

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
